// File: rtl/ntt_rom_loader.sv
// Streams 256 coefficients into a 32x96-bit NTT memory: each coefficient is
// reduced mod Q, and every eight coefficients are packed into one word.
module ntt_rom_loader #(
  parameter int Q        = 3329,
  parameter int COEFF_W  = 12,
  parameter int PER_WORD = 8,
  parameter int WORDS    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [COEFF_W-1:0]            in_data,
  output logic                          in_ready,
  output logic [PER_WORD*COEFF_W-1:0]   wdata,
  output logic [$clog2(WORDS)-1:0]      wdata_addr,
  output logic                          busy,
  output logic                          done,
  output logic                          range_err
);

  localparam int WORD_W = PER_WORD * COEFF_W;
  localparam int ACC_W  = (PER_WORD - 1) * COEFF_W;
  localparam int ADDR_W = $clog2(WORDS);
  localparam int LANE_W = $clog2(PER_WORD);
  localparam int CNT_W  = LANE_W + ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     count;
  logic [ACC_W-1:0]     acc;
  logic                 fire;
  logic                 last_lane;
  logic                 last_coeff;
  logic                 over_q;
  logic [COEFF_W-1:0]   reduced;

  // Inputs are at most 4095 < 2Q, so one conditional subtract is a full reduction.
  assign over_q     = (in_data >= COEFF_W'(Q));
  assign reduced    = over_q ? (in_data - COEFF_W'(Q)) : in_data;
  assign fire       = in_valid && (state == S_LOAD);
  assign last_lane  = (count[LANE_W-1:0] == LANE_W'(PER_WORD - 1));
  assign last_coeff = (count == CNT_W'(PER_WORD * WORDS - 1));

  // Handshake and status depend on state only, so in_ready never waits on in_valid.
  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LOAD;
      S_LOAD:   if (fire && last_coeff) next_state = S_FINISH;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      acc        <= '0;
      wdata      <= '0;
      wdata_addr <= '0;
      done       <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      done <= (state == S_FINISH);

      if ((state == S_IDLE) && start) begin
        count     <= '0;
        range_err <= 1'b0;
      end

      if (fire) begin
        count <= count + CNT_W'(1);
        if (over_q) range_err <= 1'b1;
        // The newest coefficient enters at the top, so lane 0 ends up in the low bits.
        if (last_lane) begin
          wdata      <= {reduced, acc};
          wdata_addr <= count[CNT_W-1:LANE_W];
        end else begin
          acc <= {reduced, acc[ACC_W-1:COEFF_W]};
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{WORD_W[0]};

endmodule

// File: doc/ntt_rom_loader.md
# ntt_rom_loader

Loads the NTT twiddle/coefficient memory (32 × 96-bit, write-every-cycle port) from a 12-bit coefficient stream. The block accepts 256 coefficients over a valid/ready handshake and reduces each one modulo q. It packs eight coefficients per 96-bit word and drives the memory's `wdata`/`wdata_addr` port so that word w lands at address w. It sits between the host/precompute path and the NTT memory, and signals completion so the NTT core can start reading.

## Interface
- `Q`, 3329: Kyber modulus used for input reduction.
- `COEFF_W`, 12: coefficient width.
- `PER_WORD`, 8: coefficients per memory word (`PER_WORD*COEFF_W` = 96).
- `WORDS`, 32: memory depth; address width 5.
- Only the default parameter values are required to be supported.

Ports:
- `clk`  in  1  single clock, all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  12  raw coefficient, 0..4095.
- `in_ready`  out  1  loader accepts a coefficient this cycle.
- `wdata`  out  96  word to memory; coefficient j of the word occupies bits [12j+11:12j].
- `wdata_addr`  out  5  memory write address.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse: all 32 words are in memory.
- `range_err`  out  1  sticky; an input ≥ Q was seen since the last start.

## Operation
- States: IDLE, LOAD, FINISH.
- IDLE:
  - `start`=1 → LOAD, clear the coefficient counter (8 bits, 0..255), clear `range_err`.
  - `start` in any other state is ignored.
- LOAD:
  - `in_ready`=1. A transfer occurs when `in_valid && in_ready`.
  - Reduction: stored value = `in_data` − Q if `in_data` ≥ Q, else `in_data`. This is a single conditional subtract, so 4095 → 766.
  - Any `in_data` ≥ Q sets `range_err`.
  - Transfers with counter[2:0] < 7 shift into an internal 84-bit accumulator. `wdata`/`wdata_addr` do not change.
  - Transfer with counter[2:0] = 7:
    - `wdata` ← {reduced new coeff, accumulator}.
    - `wdata_addr` ← counter[7:3].
    - Both update at the same edge.
  - Transfer at counter = 255 → FINISH.
  - Counter increments per transfer; no wrap is visible because the transfer at 255 leaves LOAD.
- FINISH: `in_ready`=0. On the next edge, `done` ← 1 and state → IDLE.
- `done` clears on the following edge.
- The memory writes on every cycle, so `wdata`/`wdata_addr` are held at the last committed word/address at all other times. Re-writing identical data is required and harmless.
- `range_err` holds its value through IDLE until the next accepted `start`.

## Timing
- Reset values:
  - state IDLE, counter 0, accumulator 0.
  - `wdata`=0, `wdata_addr`=0.
  - `in_ready`=0, `busy`=0, `done`=0, `range_err`=0.
- Reset at any point, including mid-load, returns to these values immediately. A partial word is discarded, and no further words are written beyond the zero rewrite of address 0.
- `start` sampled at edge S → `busy`=1 and `in_ready`=1 from S.
- The first transfer can occur at edge S+1.
- Eighth coefficient of word w accepted at edge E → `wdata`/`wdata_addr`=w visible after E, and the memory captures at E+1.
- Last coefficient accepted at edge E → `in_ready`=0 after E. `done`=1 and `busy`=0 after E+1, at which point the memory already holds word 31. `done`=0 after E+2.
- Minimum load time: 256 transfer cycles + 1 start cycle + 1 FINISH cycle.
- Backpressure-free: `in_ready` depends only on state, never on `in_valid`.
- Gaps in `in_valid` stall the counter without any effect on outputs.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; `in_ready`=0 until a `start`.
- Full load, `in_valid` held high, coefficient k = k:
  - Exactly 32 `wdata_addr` changes, 0..31.
  - Word w = {8w+7, …, 8w+1, 8w} in 12-bit lanes.
  - `done` pulses once, 258 cycles after `start`.
  - Memory readback of all 32 words matches.
- Random `in_valid` gaps (~50%) with the same data → identical memory contents; `wdata`/`wdata_addr` never change except on 8th-coefficient edges.
- Inputs 3328, 3329, 4095, 0 → lanes 3328, 0, 766, 0. `range_err` rises at the 3329 transfer, stays high after `done`, and clears on the next `start`.
- `start` pulsed during LOAD and FINISH → ignored: counter, outputs and the single `done` pulse are unchanged.
- `rst` after 100 coefficients, then a fresh full load → final memory equals the reference packing; no stale lanes from the aborted word.
